// File: rtl/sound_arbiter.sv
// Priority arbiter sharing one piezo between alarm, keypad beep and lullaby, with grant hold and silent guard on hand-over.
// Optional feature macro: SOUND_ARB_KEYBEEP_EN builds the keypad beep path; without it only alarm and lullaby are arbitrated.
module sound_arbiter #(
    parameter int          GUARD_CYCLES   = 50000,
    parameter int          RELEASE_CYCLES = 2500000,
    parameter int          BEEP_CYCLES    = 5000000,
    parameter logic [12:0] BEEP_NOTE      = 13'h0400
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [12:0] alarm_beat,
    input  logic [12:0] lullaby_beat,
    input  logic        key_pulse,
    input  logic        mute,
    output logic [12:0] playSound,
    output logic [2:0]  grant,
    output logic        busy,
    output logic [7:0]  preempt_cnt
);

    localparam int MAX_GR = (GUARD_CYCLES > RELEASE_CYCLES) ? GUARD_CYCLES : RELEASE_CYCLES;
    localparam int MAX_P  = (MAX_GR > BEEP_CYCLES) ? MAX_GR : BEEP_CYCLES;
    localparam int CW     = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] REL_LAST   = CW'(RELEASE_CYCLES - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PLAY_A = 3'd1,
        S_PLAY_L = 3'd2,
`ifdef SOUND_ARB_KEYBEEP_EN
        S_PLAY_B = 3'd4,
`endif
        S_GUARD  = 3'd3
    } state_t;

    state_t        state_q, state_d;
    state_t        pick_state;
    logic [CW-1:0] rel_cnt_q, rel_cnt_d;
    logic [CW-1:0] guard_cnt_q, guard_cnt_d;
    logic [12:0]   play_sound_q, play_sound_d;
    logic [7:0]    preempt_cnt_q, preempt_cnt_d;
    logic          preempt_evt;
    logic          req_a;
    logic          req_l;
    logic          beep_req;

    assign req_a = (alarm_beat != 13'd0);
    assign req_l = (lullaby_beat != 13'd0);

`ifdef SOUND_ARB_KEYBEEP_EN
    localparam logic [CW-1:0] BEEP_LAST = CW'(BEEP_CYCLES - 1);

    logic          beep_pend_q, beep_pend_d;
    logic [CW-1:0] beep_cnt_q, beep_cnt_d;

    assign beep_req = beep_pend_q;
`else
    logic unused_beep;

    assign beep_req    = 1'b0;
    assign unused_beep = ^{key_pulse, BEEP_NOTE};
`endif

    // Highest-priority requester, used from IDLE and on the last guard clock.
    always_comb begin
        pick_state = S_IDLE;
        if (req_a) begin
            pick_state = S_PLAY_A;
        end
`ifdef SOUND_ARB_KEYBEEP_EN
        else if (beep_req) begin
            pick_state = S_PLAY_B;
        end
`endif
        else if (req_l) begin
            pick_state = S_PLAY_L;
        end
    end

    always_comb begin
        state_d       = state_q;
        rel_cnt_d     = rel_cnt_q;
        guard_cnt_d   = guard_cnt_q;
        preempt_cnt_d = preempt_cnt_q;
        preempt_evt   = 1'b0;
        play_sound_d  = 13'd0;
`ifdef SOUND_ARB_KEYBEEP_EN
        beep_cnt_d    = beep_cnt_q;
        beep_pend_d   = beep_pend_q;
`endif

        case (state_q)
            S_IDLE: begin
                rel_cnt_d = '0;
                state_d   = pick_state;
            end
            S_PLAY_A: begin
                if (req_a) begin
                    rel_cnt_d = '0;
                end else if (rel_cnt_q == REL_LAST) begin
                    rel_cnt_d = '0;
                    state_d   = S_GUARD;
                end else begin
                    rel_cnt_d = rel_cnt_q + CNT_ONE;
                end
            end
            S_PLAY_L: begin
                if (req_a || beep_req) begin
                    rel_cnt_d   = '0;
                    state_d     = S_GUARD;
                    preempt_evt = 1'b1;
                end else if (req_l) begin
                    rel_cnt_d = '0;
                end else if (rel_cnt_q == REL_LAST) begin
                    rel_cnt_d = '0;
                    state_d   = S_GUARD;
                end else begin
                    rel_cnt_d = rel_cnt_q + CNT_ONE;
                end
            end
`ifdef SOUND_ARB_KEYBEEP_EN
            S_PLAY_B: begin
                if (req_a) begin
                    beep_cnt_d  = '0;
                    state_d     = S_GUARD;
                    preempt_evt = 1'b1;
                end else if (key_pulse) begin
                    beep_cnt_d = '0;
                end else if (beep_cnt_q == BEEP_LAST) begin
                    beep_cnt_d = '0;
                    state_d    = S_GUARD;
                end else begin
                    beep_cnt_d = beep_cnt_q + CNT_ONE;
                end
            end
`endif
            S_GUARD: begin
                if (guard_cnt_q == GUARD_LAST) begin
                    guard_cnt_d = '0;
                    state_d     = pick_state;
                end else begin
                    guard_cnt_d = guard_cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (preempt_evt && (preempt_cnt_q != 8'hFF)) begin
            preempt_cnt_d = preempt_cnt_q + 8'd1;
        end

`ifdef SOUND_ARB_KEYBEEP_EN
        // Entry into the beep consumes the pending flag; presses during alarm or beep never latch.
        if ((state_d == S_PLAY_B) && (state_q != S_PLAY_B)) begin
            beep_pend_d = 1'b0;
        end else if (key_pulse && !req_a && (state_q != S_PLAY_A) && (state_q != S_PLAY_B)) begin
            beep_pend_d = 1'b1;
        end
`endif

        // Beat codes pass through one register only while the grant is kept, so any hand-over is silent at once.
        if (!mute) begin
            if ((state_q == S_PLAY_A) && (state_d == S_PLAY_A)) begin
                play_sound_d = alarm_beat;
            end else if ((state_q == S_PLAY_L) && (state_d == S_PLAY_L)) begin
                play_sound_d = lullaby_beat;
            end
`ifdef SOUND_ARB_KEYBEEP_EN
            else if (state_d == S_PLAY_B) begin
                play_sound_d = BEEP_NOTE;
            end
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            rel_cnt_q     <= '0;
            guard_cnt_q   <= '0;
            play_sound_q  <= 13'd0;
            preempt_cnt_q <= 8'd0;
`ifdef SOUND_ARB_KEYBEEP_EN
            beep_cnt_q    <= '0;
            beep_pend_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            rel_cnt_q     <= rel_cnt_d;
            guard_cnt_q   <= guard_cnt_d;
            play_sound_q  <= play_sound_d;
            preempt_cnt_q <= preempt_cnt_d;
`ifdef SOUND_ARB_KEYBEEP_EN
            beep_cnt_q    <= beep_cnt_d;
            beep_pend_q   <= beep_pend_d;
`endif
        end
    end

    assign playSound   = play_sound_q;
    assign busy        = (state_q != S_IDLE);
    assign preempt_cnt = preempt_cnt_q;
`ifdef SOUND_ARB_KEYBEEP_EN
    assign grant = {state_q == S_PLAY_A, state_q == S_PLAY_B, state_q == S_PLAY_L};
`else
    assign grant = {state_q == S_PLAY_A, 1'b0, state_q == S_PLAY_L};
`endif

endmodule
